// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, registers the instruction memory word into a
// valid/ready IF/ID slot, applies execute redirects. Halt detection under FETCH_HALT_DETECT_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_INSN = 32'h0000_0063
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic        halted,
  output logic        fault,
  output logic [31:0] fetch_count
);

  // Handshake: the slot transfers to decode on a cycle where if_valid && if_ready.
  // Once if_valid is high, the slot contents stay stable until that transfer or a redirect.

`ifdef FETCH_HALT_DETECT_EN
  typedef enum logic [1:0] {RUN = 2'd0, HALT_PEND = 2'd1, HALTED = 2'd2, FAULT = 2'd3} state_t;
`else
  typedef enum logic [1:0] {RUN = 2'd0, FAULT = 2'd3} state_t;
`endif

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic        if_valid_n;
  logic [31:0] if_instr_n, if_pc_n, fetch_count_n;
  logic        accept, slot_free;

  assign accept      = if_valid && if_ready;
  assign slot_free   = !if_valid || accept;
  assign imem_addr   = pc;
  assign if_pc_plus4 = if_pc + 32'd4;
  assign fault       = (state == FAULT);

`ifdef FETCH_HALT_DETECT_EN
  assign halted = (state == HALTED);
`else
  logic unused_halt_insn;
  assign unused_halt_insn = ^HALT_INSN;
  assign halted = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      pc          <= RESET_PC;
      if_valid    <= 1'b0;
      if_instr    <= 32'd0;
      if_pc       <= 32'd0;
      fetch_count <= 32'd0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      if_valid    <= if_valid_n;
      if_instr    <= if_instr_n;
      if_pc       <= if_pc_n;
      fetch_count <= fetch_count_n;
    end
  end

  always_comb begin
    state_n       = state;
    pc_n          = pc;
    if_valid_n    = if_valid;
    if_instr_n    = if_instr;
    if_pc_n       = if_pc;
    // An accept counts even when a redirect flushes the slot in the same cycle.
    fetch_count_n = fetch_count + {31'd0, accept};

    case (state)
      RUN: begin
        if (redirect_valid) begin
          if_valid_n = 1'b0;
          if (redirect_pc[1:0] == 2'b00) begin
            pc_n    = redirect_pc;
            state_n = RUN;
          end else begin
            state_n = FAULT;
          end
        end else if (slot_free) begin
          if_instr_n = imem_instr;
          if_pc_n    = pc;
          if_valid_n = 1'b1;
`ifdef FETCH_HALT_DETECT_EN
          // The PC stays parked on the halt word.
          if (imem_instr == HALT_INSN) state_n = HALT_PEND;
          else                         pc_n    = pc + 32'd4;
`else
          pc_n = pc + 32'd4;
`endif
        end
      end
`ifdef FETCH_HALT_DETECT_EN
      HALT_PEND: begin
        if (redirect_valid) begin
          if_valid_n = 1'b0;
          if (redirect_pc[1:0] == 2'b00) begin
            pc_n    = redirect_pc;
            state_n = RUN;
          end else begin
            state_n = FAULT;
          end
        end else if (accept && (if_instr == HALT_INSN)) begin
          if_valid_n = 1'b0;
          state_n    = HALTED;
        end
      end
      HALTED: begin
        if_valid_n = 1'b0;
      end
`endif
      FAULT: begin
        if_valid_n = 1'b0;
      end
      default: begin
        if_valid_n = 1'b0;
        state_n    = FAULT;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: small ROM model, linear step sequence, immediate-assertion checks.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic        halted;
  logic        fault;
  logic [31:0] fetch_count;

  int total = 0;
  int bad   = 0;

  fetch_unit #(.RESET_PC(32'h0), .HALT_INSN(32'h0000_0063)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_addr(imem_addr), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready),
    .if_instr(if_instr), .if_pc(if_pc), .if_pc_plus4(if_pc_plus4),
    .halted(halted), .fault(fault), .fetch_count(fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory model; anything outside the listed words is a nop,
  // beyond 0x7C it returns the halt word.
  always_comb begin
    if (imem_addr >= 32'h80) imem_instr = 32'h0000_0063;
    else begin
      case (imem_addr)
        32'h00:  imem_instr = 32'h0050_0093;
        32'h04:  imem_instr = 32'h0010_0113;
        32'h08:  imem_instr = 32'h0020_0193;
        32'h0C:  imem_instr = 32'h0000_0063;
        32'h10:  imem_instr = 32'h0030_0213;
        32'h40:  imem_instr = 32'h0040_0293;
        32'h44:  imem_instr = 32'h0050_0313;
        default: imem_instr = 32'h0000_0013;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n          = 1'b0;
    if_ready       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    #3;
    chk("rst_imem_addr", imem_addr, 32'h0);
    chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_if_instr", if_instr, 32'h0);
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_if_pc_plus4", if_pc_plus4, 32'h4);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_fetch_count", fetch_count, 32'd0);

    step();
    rst_n = 1'b1;
    step();  // capture word at 0x0
    chk("cap0_valid", {31'd0, if_valid}, 32'd1);
    chk("cap0_pc", if_pc, 32'h0);
    chk("cap0_instr", if_instr, 32'h0050_0093);
    chk("cap0_imem_addr", imem_addr, 32'h4);

    // Stall three cycles: slot, pc and count frozen.
    if_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_instr", if_instr, 32'h0050_0093);
      chk("stall_pc", if_pc, 32'h0);
      chk("stall_imem_addr", imem_addr, 32'h4);
      chk("stall_count", fetch_count, 32'd0);
    end
    if_ready = 1'b1;
    step();
    chk("acc1_count", fetch_count, 32'd1);
    chk("acc1_pc", if_pc, 32'h4);
    chk("acc1_instr", if_instr, 32'h0010_0113);
    step();
    chk("acc2_count", fetch_count, 32'd2);
    chk("acc2_pc", if_pc, 32'h8);
    chk("acc2_plus4", if_pc_plus4, 32'hC);

    // Redirect to 0x40 while the slot at 0x8 is being accepted.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    step();
    redirect_valid = 1'b0;
    chk("redir_flush_valid", {31'd0, if_valid}, 32'd0);
    chk("redir_count", fetch_count, 32'd3);
    chk("redir_imem_addr", imem_addr, 32'h40);
    step();
    chk("redir_tgt_valid", {31'd0, if_valid}, 32'd1);
    chk("redir_tgt_pc", if_pc, 32'h40);
    chk("redir_tgt_instr", if_instr, 32'h0040_0293);
    chk("redir_tgt_plus4", if_pc_plus4, 32'h44);
    chk("redir_tgt_count", fetch_count, 32'd3);

    // Head back to 0x8 so the halt word at 0xC is fetched.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8;
    step();
    redirect_valid = 1'b0;
    chk("r8_count", fetch_count, 32'd4);
    step();
    chk("r8_pc", if_pc, 32'h8);
    step();
    chk("halt_cap_pc", if_pc, 32'hC);
    chk("halt_cap_instr", if_instr, 32'h0000_0063);
    chk("halt_cap_count", fetch_count, 32'd5);
`ifdef FETCH_HALT_DETECT_EN
    chk("halt_pc_parked", imem_addr, 32'hC);
    step();
    chk("halted_rise", {31'd0, halted}, 32'd1);
    chk("halted_valid", {31'd0, if_valid}, 32'd0);
    chk("halted_count", fetch_count, 32'd6);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0;
    step();
    step();
    redirect_valid = 1'b0;
    chk("halted_redir_ignored", imem_addr, 32'hC);
    chk("halted_sticky", {31'd0, halted}, 32'd1);
    chk("halted_no_cap", {31'd0, if_valid}, 32'd0);
`else
    chk("nohalt_pc_adv", imem_addr, 32'h10);
    step();
    chk("nohalt_next_pc", if_pc, 32'h10);
    chk("nohalt_next_instr", if_instr, 32'h0030_0213);
    chk("nohalt_halted", {31'd0, halted}, 32'd0);
    chk("nohalt_count", fetch_count, 32'd6);
`endif

    // Asynchronous reset mid-cycle, no clock edge needed.
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, if_valid}, 32'd0);
    chk("async_rst_count", fetch_count, 32'd0);
    chk("async_rst_halted", {31'd0, halted}, 32'd0);
    chk("async_rst_addr", imem_addr, 32'h0);
    step();
    rst_n = 1'b1;
    step();
    chk("rerun_pc", if_pc, 32'h0);
    chk("rerun_valid", {31'd0, if_valid}, 32'd1);

    // Misaligned redirect lands in FAULT, pc unchanged, later redirects ignored.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h42;
    step();
    chk("fault_rise", {31'd0, fault}, 32'd1);
    chk("fault_valid", {31'd0, if_valid}, 32'd0);
    chk("fault_pc_held", imem_addr, 32'h4);
    chk("fault_count", fetch_count, 32'd1);
    redirect_pc = 32'h40;
    step();
    redirect_valid = 1'b0;
    chk("fault_sticky", {31'd0, fault}, 32'd1);
    chk("fault_redir_ignored", imem_addr, 32'h4);
    step();
    chk("fault_valid_held", {31'd0, if_valid}, 32'd0);

    rst_n = 1'b0;
    #1;
    chk("fault_clr", {31'd0, fault}, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("post_fault_pc", if_pc, 32'h0);
    chk("post_fault_valid", {31'd0, if_valid}, 32'd1);
    chk("post_fault_fault", {31'd0, fault}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
